average_ctrl: RTL and testbench

Sequencer for the 4-bit sample averager. Takes samples from an upstream source over a valid/ready handshake and clears the averager at window start. Feeds exactly 2^WIN_LOG2 samples into it with `x_load` pulses, waits out the averager latency, then captures the result and offers it downstream over a valid/ready handshake. Sits between the sample source and the averager datapath, and owns all of the averager's control inputs.

---
 rtl/average_ctrl_pkg.sv | 17 +
 rtl/avg_win_cnt.sv | 31 +++
 rtl/average_ctrl.sv | 98 +++++++++
 tb/tb_average_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/average_ctrl_pkg.sv
// Shared types and defaults for the sample-averager sequencer.
package average_pkg;

    localparam int unsigned DW_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        WAIT,
        DONE
    } avg_state_t;

    localparam avg_state_t STATE_RST = IDLE;
    localparam logic       BIT_RST   = 1'b0;

endpackage

// File: rtl/avg_win_cnt.sv
// Loadable up/down window counter with clear, enable and terminal-count flag.
module avg_win_cnt #(
    parameter int unsigned W      = 3,
    parameter bit          UP     = 1'b1,
    parameter int unsigned TC_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= UP ? cnt + W'(1) : cnt - W'(1);
    end

    assign tc = (cnt == W'(TC_VAL));

endmodule

// File: rtl/average_ctrl.sv
// Sequencer feeding a window of samples into the averager and handing its result downstream.
module average_ctrl
    import average_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned WIN_LOG2 = 2,
    parameter int unsigned LAT      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          avg_clr,
    output logic          x_load,
    output logic [DW-1:0] x,
    input  logic [DW-1:0] avg_y,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    input  logic          res_ready,
    output logic          busy
);

    localparam int unsigned SW = WIN_LOG2 + 1;
    localparam int unsigned LW = $clog2(LAT) + 1;

    avg_state_t state, state_nxt;
    logic       hs, samp_tc, wait_tc, last_hs, capture;

    assign hs      = s_valid & (state == LOAD);
    assign last_hs = hs & samp_tc;
    assign capture = (state == WAIT) & wait_tc & ~abort;

    // Sample counter wraps to zero on the N-th handshake, same edge as LOAD -> WAIT.
    avg_win_cnt #(.W(SW), .UP(1'b1), .TC_VAL((1 << WIN_LOG2) - 1)) u_samp_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      ((state == CLR) | abort | last_hs),
        .load     (1'b0),
        .load_val ('0),
        .en       (hs),
        .tc       (samp_tc)
    );

    avg_win_cnt #(.W(LW), .UP(1'b0), .TC_VAL(0)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .load     (last_hs),
        .load_val (LW'(LAT - 1)),
        .en       ((state == WAIT) & ~wait_tc),
        .tc       (wait_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= STATE_RST;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CLR;
            CLR:  state_nxt = LOAD;
            LOAD: if (last_hs) state_nxt = WAIT;
            WAIT: if (wait_tc) state_nxt = DONE;
            DONE: if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    assign s_ready   = (state == LOAD);
    assign avg_clr   = (state == CLR);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // A sample handshaken during abort is consumed but never forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_load   <= BIT_RST;
            x        <= '0;
            res_data <= '0;
        end else begin
            x_load <= hs & ~abort;
            if (hs & ~abort)
                x <= s_data;
            if (capture)
                res_data <= avg_y;
        end
    end

endmodule

// File: tb/tb_average_ctrl.sv
// Directed bench for average_ctrl with a behavioural sum>>2 averager model.
module tb_average_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, s_valid, res_ready;
    logic [3:0] s_data;
    logic       s_ready, avg_clr, x_load, res_valid, busy;
    logic [3:0] x, res_data, avg_y;
    logic [5:0] acc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    average_ctrl #(.DW(4), .WIN_LOG2(2), .LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .avg_clr   (avg_clr),
        .x_load    (x_load),
        .x         (x),
        .avg_y     (avg_y),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy)
    );

    // Averager model: accumulator register, y = sum >> 2.
    always @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (avg_clr)
            acc <= '0;
        else if (x_load)
            acc <= acc + {2'b00, x};
    end
    assign avg_y = acc[5:2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_window();
        start = 1'b1;
        tick();
        chk("start_clr", 32'(avg_clr), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_sready_low", 32'(s_ready), 0);
        start = 1'b0;
        tick();
        chk("load_sready", 32'(s_ready), 1);
        chk("load_clr_low", 32'(avg_clr), 0);
    endtask

    logic [3:0] nom [4]  = '{4'd5, 4'd7, 4'd4, 4'd8};
    logic [3:0] gap [4]  = '{4'd15, 4'd15, 4'd0, 4'd0};
    logic       gpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int gi, loads, qi;
        logic hs_now;
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        s_data = '0; res_ready = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_res_data", 32'(res_data), 0);
        rst = 1'b0;
        tick();

        // Async reset mid-LOAD
        begin_window();
        s_valid = 1'b1; s_data = 4'd9;
        tick();
        chk("pre_rst_xload", 32'(x_load), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_outputs", {26'd0, s_ready, avg_clr, x_load, res_valid, busy, 1'b0}, 0);
        chk("arst_x", 32'(x), 0);
        #1 rst = 1'b0;
        s_valid = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        // Nominal window 5,7,4,8 -> 6
        begin_window();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = nom[i];
            tick();
            chk("nom_xload", 32'(x_load), 1);
            chk("nom_x", 32'(x), 32'(nom[i]));
        end
        s_valid = 1'b0;
        chk("nom_sready_drop", 32'(s_ready), 0);
        tick();
        chk("nom_xload_idle", 32'(x_load), 0);
        chk("nom_wait_valid", 32'(res_valid), 0);
        tick();
        chk("nom_res_valid", 32'(res_valid), 1);
        chk("nom_res_data", 32'(res_data), 6);
        res_ready = 1'b1;
        tick();
        chk("nom_idle", 32'(busy), 0);
        chk("nom_valid_drop", 32'(res_valid), 0);
        res_ready = 1'b0;

        // Source gaps: 15,15,0,0 -> 7
        begin_window();
        gi = 0; loads = 0;
        for (int i = 0; i < 7; i++) begin
            s_valid = gpat[i];
            s_data = gpat[i] ? gap[gi] : 4'd3;
            tick();
            chk("gap_xload", 32'(x_load), 32'(gpat[i]));
            if (x_load) loads++;
            if (gpat[i]) begin
                chk("gap_x", 32'(x), 32'(gap[gi]));
                gi++;
            end
        end
        s_valid = 1'b0;
        chk("gap_loads", 32'(loads), 4);
        tick();
        tick();
        chk("gap_res_valid", 32'(res_valid), 1);
        chk("gap_res_data", 32'(res_data), 7);

        // Back-pressure with ignored start pulses
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            tick();
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_data", 32'(res_data), 7);
            chk("bp_clr_low", 32'(avg_clr), 0);
        end
        res_ready = 1'b1; start = 1'b1;
        tick();
        chk("bp_idle", 32'(busy), 0);
        start = 1'b0; res_ready = 1'b0;
        tick();
        chk("bp_no_queued_start", 32'(busy), 0);

        // Abort on 3rd handshake
        begin_window();
        for (int i = 1; i <= 2; i++) begin
            s_valid = 1'b1; s_data = 4'(i);
            tick();
        end
        s_data = 4'd3; abort = 1'b1;
        tick();
        abort = 1'b0; s_valid = 1'b0;
        chk("abort_idle", 32'(busy), 0);
        chk("abort_xload", 32'(x_load), 0);
        chk("abort_x_hold", 32'(x), 2);
        chk("abort_valid", 32'(res_valid), 0);
        chk("abort_res_hold", 32'(res_data), 7);
        tick();
        chk("abort_xload2", 32'(x_load), 0);
        begin_window();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 4'd8;
            tick();
        end
        s_valid = 1'b0;
        tick();
        tick();
        chk("reab_res_valid", 32'(res_valid), 1);
        chk("reab_res_data", 32'(res_data), 8);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Window boundary: 6 samples queued, only 4 taken
        begin_window();
        qi = 0;
        for (int i = 0; i < 6; i++) begin
            s_valid = (qi < 6);
            s_data = 4'(qi + 1);
            hs_now = s_valid & s_ready;
            tick();
            if (hs_now) qi++;
        end
        chk("bnd_accepted", 32'(qi), 4);
        chk("bnd_sready_low", 32'(s_ready), 0);
        chk("bnd_src_holds5", 32'(s_data), 5);
        chk("bnd_res_valid", 32'(res_valid), 1);
        chk("bnd_res_data", 32'(res_data), 2);
        s_valid = 1'b0; res_ready = 1'b1;
        tick();
        chk("bnd_idle", 32'(busy), 0);
        res_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
